// File: rtl/genius_input_checker.sv
// Genius player-side checker: walks the sequence ROM step by step and compares one-hot presses.
// Optional press timeout is compiled in with `define GENIUS_CHECK_TIMEOUT_EN.
module genius_input_checker #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] level,
  input  logic [3:0] buttons,
  input  logic [3:0] expected,
  output logic [3:0] addr,
  output logic       busy,
  output logic       success,
  output logic       fail,
  output logic [1:0] dbg_state
);

  // Handshake: start is taken only when busy=0 (IDLE); busy stays high from the accepted
  // start until the edge that produces the success/fail pulse, and start is ignored meanwhile.
  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_REL   = 2'd1,
    S_WAIT_PRESS = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] addr_q, addr_d;
  logic [3:0] level_q, level_d;
  logic [3:0] prev_buttons_q;
  logic       busy_q, busy_d;
  logic       success_q, success_d;
  logic       fail_q, fail_d;

  logic       press_event;
  logic       press_ok;
  logic       timed_out;

  assign press_event = (buttons != 4'd0) && (prev_buttons_q == 4'd0);
  // A correct press must be exactly one button and equal to the ROM colour.
  assign press_ok    = (buttons == expected) && ((buttons & (buttons - 4'd1)) == 4'd0);

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_param_out_of_range
  end

`ifdef GENIUS_CHECK_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign timed_out = (state_q == S_WAIT_PRESS) && (cnt_q == TERMINAL);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_WAIT_REL && buttons == 4'd0) begin
      cnt_d = '0;
    end else if (state_q == S_WAIT_PRESS) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    level_d   = level_q;
    busy_d    = busy_q;
    success_d = 1'b0;
    fail_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          level_d = level;
          addr_d  = 4'd0;
          busy_d  = 1'b1;
          state_d = S_WAIT_REL;
        end
      end
      S_WAIT_REL: begin
        if (buttons == 4'd0) begin
          state_d = S_WAIT_PRESS;
        end
      end
      S_WAIT_PRESS: begin
        // A press on the terminal-count cycle wins over the timeout.
        if (press_event) begin
          if (press_ok && addr_q == level_q) begin
            success_d = 1'b1;
            busy_d    = 1'b0;
            state_d   = S_IDLE;
          end else if (press_ok && addr_q < level_q) begin
            addr_d  = addr_q + 4'd1;
            state_d = S_WAIT_REL;
          end else begin
            fail_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else if (timed_out) begin
          fail_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      addr_q         <= 4'd0;
      level_q        <= 4'd0;
      prev_buttons_q <= 4'd0;
      busy_q         <= 1'b0;
      success_q      <= 1'b0;
      fail_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      level_q        <= level_d;
      prev_buttons_q <= buttons;
      busy_q         <= busy_d;
      success_q      <= success_d;
      fail_q         <= fail_d;
    end
  end

  assign addr      = addr_q;
  assign busy      = busy_q;
  assign success   = success_q;
  assign fail      = fail_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_genius_input_checker.sv
// Directed bench for genius_input_checker: verdicts go through an expected queue checked by a monitor.
module tb_genius_input_checker;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] level;
  logic [3:0] buttons;
  logic [3:0] expected;
  logic [3:0] addr;
  logic       busy;
  logic       success;
  logic       fail;
  logic [1:0] dbg_state;

  logic [3:0] rom [16];
  logic [5:0] exp_q [$];
  int pass_cnt;
  int total_cnt;

  genius_input_checker #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .level(level),
    .buttons(buttons), .expected(expected), .addr(addr), .busy(busy),
    .success(success), .fail(fail), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign expected = rom[addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // verdict encoding: {success, fail, addr}
  task automatic push_exp(input logic s, input logic f, input logic [3:0] a);
    exp_q.push_back({s, f, a});
  endtask

  task automatic do_start(input logic [3:0] lvl);
    start = 1'b1;
    level = lvl;
    tick(1);
    start = 1'b0;
    tick(1);
  endtask

  // verdict: 0 none, 1 success, 2 fail
  task automatic press(input logic [3:0] b, input int verdict, input logic [3:0] vaddr);
    if (verdict == 1) push_exp(1'b1, 1'b0, vaddr);
    if (verdict == 2) push_exp(1'b0, 1'b1, vaddr);
    buttons = b;
    tick(3);
    buttons = 4'd0;
    tick(2);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && (success || fail)) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL verdict_unexpected: got s=%0b f=%0b addr=%0d expected none", success, fail, addr);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        if ({success, fail, addr} === e) pass_cnt++;
        else $display("FAIL verdict: got s=%0b f=%0b addr=%0d expected s=%0b f=%0b addr=%0d",
                      success, fail, addr, e[5], e[4], e[3:0]);
      end
    end
  end

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    for (int i = 0; i < 16; i++) rom[i] = 4'b0001;
    rom[0] = 4'b0001;
    rom[1] = 4'b0100;
    rom[2] = 4'b0001;
    rom[3] = 4'b1000;
    rst_n = 1'b0; start = 1'b0; level = 4'd0; buttons = 4'd0;
    tick(2);
    check("reset_addr", 32'(addr), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_pulses", 32'({success, fail}), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // full round, level 2
    do_start(4'd2);
    check("start_busy", 32'(busy), 32'd1);
    check("start_addr", 32'(addr), 32'd0);
    press(4'b0001, 0, 4'd0);
    check("round_addr1", 32'(addr), 32'd1);
    press(4'b0100, 0, 4'd0);
    check("round_addr2", 32'(addr), 32'd2);
    press(4'b0001, 1, 4'd2);
    check("round_busy_done", 32'(busy), 32'd0);
    check("round_addr_hold", 32'(addr), 32'd2);

    // wrong colour at step 1
    do_start(4'd2);
    press(4'b0001, 0, 4'd0);
    press(4'b0010, 2, 4'd1);
    check("wrong_addr_hold", 32'(addr), 32'd1);
    check("wrong_busy", 32'(busy), 32'd0);

    // button held across start
    buttons = 4'b0001;
    do_start(4'd0);
    tick(20);
    check("held_busy", 32'(busy), 32'd1);
    check("held_state", 32'(dbg_state), 32'd1);
    buttons = 4'd0;
    tick(2);
    press(4'b0001, 1, 4'd0);

    // multi-button press
    do_start(4'd0);
    press(4'b0101, 2, 4'd0);
    check("multi_busy", 32'(busy), 32'd0);

    // start while busy is ignored
    do_start(4'd2);
    press(4'b0001, 0, 4'd0);
    start = 1'b1; level = 4'd0;
    tick(1);
    start = 1'b0;
    tick(1);
    check("busy_start_addr", 32'(addr), 32'd1);
    check("busy_start_busy", 32'(busy), 32'd1);
    press(4'b0100, 0, 4'd0);
    check("busy_start_addr2", 32'(addr), 32'd2);
    press(4'b0001, 1, 4'd2);

    // reset mid-round
    do_start(4'd3);
    press(4'b0001, 0, 4'd0);
    buttons = 4'b0100;
    rst_n = 1'b0;
    tick(1);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pulses", 32'({success, fail}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    buttons = 4'd0;
    rst_n = 1'b1;
    tick(2);

`ifdef GENIUS_CHECK_TIMEOUT_EN
    // timeout after 8 cycles in WAIT_PRESS
    do_start(4'd0);
    push_exp(1'b0, 1'b1, 4'd0);
    tick(7);
    check("to_not_yet", 32'(fail), 32'd0);
    tick(1);
    check("to_fail", 32'(fail), 32'd1);
    check("to_busy", 32'(busy), 32'd0);
    tick(1);
    // press on terminal-count cycle
    do_start(4'd0);
    tick(7);
    push_exp(1'b1, 1'b0, 4'd0);
    buttons = 4'b0001;
    tick(1);
    check("tc_press_success", 32'(success), 32'd1);
    buttons = 4'd0;
    tick(2);
`else
    // without timeout the checker waits indefinitely
    do_start(4'd0);
    tick(30);
    check("no_to_busy", 32'(busy), 32'd1);
    press(4'b0001, 1, 4'd0);
`endif

    tick(3);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/genius_input_checker.md
# genius_input_checker

Player-side checker for the Genius game. It reads the expected colour sequence from the sequence ROM one address at a time and compares it against the player's one-hot button presses. It emits a single-cycle success or fail verdict for the round. It sits between the button synchronisers and the game-control FSM, and drives the ROM address while the game is in the "player repeats" phase.

## Interface
- `TIMEOUT_CYCLES`, default 1000: maximum clock cycles allowed between accepted presses (≥2). Only used when the timeout feature is compiled in.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  single-cycle request to begin checking a round; ignored while `busy`=1.
- `level`  in  4  index of the last step of the round (0..15). Sampled on an accepted `start`.
- `buttons`  in  4  synchronised button levels, one-hot colour code (0001, 0010, 0100, 1000).
- `expected`  in  4  sequence ROM data for `addr`, combinational.
- `addr`  out  4  sequence ROM address; equals the current step index.
- `busy`  out  1  high from the accepted `start` until the verdict.
- `success`  out  1  one-cycle pulse: all steps 0..level matched.
- `fail`  out  1  one-cycle pulse: wrong press, multi-button press, or timeout.

## Operation
- All outputs registered. Reset values: `addr`=0, `busy`=0, `success`=0, `fail`=0, FSM=IDLE, `prev_buttons`=0, level register=0, timeout counter=0.
- `prev_buttons` register holds the `buttons` value from the previous cycle. A press event is a cycle where `buttons`≠0 and `prev_buttons`=0.
- FSM states and transitions:
  - IDLE: on `start`, latch `level`, set `addr`=0, set `busy`=1, go to WAIT_REL.
  - WAIT_REL: remain while `buttons`≠0. When `buttons`=0, go to WAIT_PRESS and clear the timeout counter.
  - WAIT_PRESS: on a press event, evaluate:
    - `buttons`==`expected` and `addr`==level: pulse `success`, clear `busy`, go to IDLE.
    - `buttons`==`expected` and `addr`<level: `addr`+1, go to WAIT_REL.
    - Any other value, including multiple bits set or any mismatch: pulse `fail`, clear `busy`, go to IDLE.
- `success` and `fail` are mutually exclusive and are never asserted outside the verdict cycle.
- `addr` holds its last value in IDLE, so the ROM output remains stable for the controller.
- `addr` is 4-bit. With level=15 the final step is addr=15, and `addr` never increments past level, so it never wraps.
- `start` asserted in any state other than IDLE is ignored; the latched level is unchanged.
- `buttons` changing while in WAIT_REL has no effect until `buttons`=0.
- If `rst_n`=0 in any state, the next edge forces the reset values. No verdict pulse is produced for the aborted round.

## Timing
- `start` accepted at edge N: `busy`=1 and `addr`=0 visible after edge N.
- With buttons released, WAIT_PRESS is entered at edge N+1. A press first seen on `buttons` before edge M is evaluated at edge M. The verdict or the `addr` increment is visible after edge M.
- One press consumes exactly one step. A button held for many cycles counts once.
- `expected` must settle within the same cycle that `addr` changes (combinational ROM).
- Verdict to next accepted `start`: minimum 1 cycle, because IDLE is entered immediately after the verdict.

## Configuration
- `GENIUS_CHECK_TIMEOUT_EN` defined: in WAIT_PRESS the counter increments every cycle and is cleared on entry to WAIT_PRESS. When the counter reaches `TIMEOUT_CYCLES`-1 with no press event, `fail` is pulsed, `busy` is cleared and the FSM goes to IDLE. A press in the same cycle as the terminal count takes priority and is evaluated normally.
- Not defined: no counter is present, and WAIT_PRESS waits indefinitely. `TIMEOUT_CYCLES` has no effect.

## Test plan
- ROM 0001,0100,0001; level=2; presses 0001, 0100, 0001, each released between presses. Required: `addr` steps 0→1→2, one `success` pulse on the third press, `busy` 1→0 on that edge, `fail` never asserted.
- Level=2; presses 0001, then 0010 at step 1. Required: `fail` pulse on the second press, `addr`=1 held, `success` never asserted.
- Level=0; `buttons` already 0001 when `start` is asserted and held for 20 cycles. Required: no verdict while held. After release, a new press of 0001 gives `success`.
- Level=0; press 0101. Required: `fail` pulse. Separately, `start` asserted while `busy`=1 is ignored and `addr` is unchanged.
- `GENIUS_CHECK_TIMEOUT_EN` defined, TIMEOUT_CYCLES=8, no press. Required: `fail` exactly 8 cycles after entering WAIT_PRESS. A press on the terminal-count cycle is evaluated instead of timing out.
- `rst_n` driven low at step 1 of a level=3 round. Required: next edge gives `addr`=0, `busy`=0, no `success` or `fail`, FSM returns to IDLE.
